layer_sequencer: RTL and testbench

Walks a table of per-layer convolution descriptors and drives the Issue stage through one layer after another. For each layer it fetches a descriptor, checks it, loads the Issue configuration (image dim/depth, filter halfsize/stride), holds Issue in reset while loading, releases it, and waits for Issue `done`. Between layers it flips the ping-pong memory bank select. It sits between the host/top-level control and the Issue stage.

---
 rtl/layer_seq_pkg.sv | 38 +++
 rtl/layer_desc_check.sv | 37 +++
 rtl/layer_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_layer_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_seq_pkg.sv
// ============================================================================
// Module   : layer_seq_pkg
// Brief    : Shared types and descriptor field layout for the layer sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package layer_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_ARM   = 3'd3,
        ST_RUN   = 3'd4,
        ST_NEXT  = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERROR = 3'd7
    } seq_state_t;

    localparam int DESC_W     = 23;
    localparam int DIM_LSB    = 0;
    localparam int DIM_W      = 8;
    localparam int DEPTH_LSB  = 8;
    localparam int DEPTH_W    = 9;
    localparam int HS_LSB     = 17;
    localparam int HS_W       = 2;
    localparam int STRIDE_LSB = 19;
    localparam int STRIDE_W   = 3;
    localparam int LAST_BIT   = 22;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_DESC    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

`default_nettype wire

// File: rtl/layer_desc_check.sv
// ============================================================================
// Module   : layer_desc_check
// Brief    : Combinational sanity check of one layer descriptor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_desc_check
    import layer_seq_pkg::*;
(
    input  logic [DESC_W-1:0] desc,
    output logic              valid
);

    logic [DIM_W-1:0]    w_dim;
    logic [DEPTH_W-1:0]  w_depth;
    logic [HS_W-1:0]     w_hs;
    logic [STRIDE_W-1:0] w_stride;
    logic [8:0]          w_min_dim;
    logic                w_unused_last;

    assign w_dim         = desc[DIM_LSB +: DIM_W];
    assign w_depth       = desc[DEPTH_LSB +: DEPTH_W];
    assign w_hs          = desc[HS_LSB +: HS_W];
    assign w_stride      = desc[STRIDE_LSB +: STRIDE_W];
    assign w_unused_last = desc[LAST_BIT];

    // Filter footprint (2*halfsize+1) must fit in the image; 9 bits avoid wrap.
    assign w_min_dim = {6'd0, w_hs, 1'b0} + 9'd1;

    assign valid = (w_dim != '0) && (w_depth != '0) &&
                   (w_stride >= 3'd1) && (w_stride <= 3'd4) &&
                   ({1'b0, w_dim} >= w_min_dim);

endmodule

`default_nettype wire

// File: rtl/layer_sequencer.sv
// ============================================================================
// Module   : layer_sequencer
// Brief    : Walks the layer descriptor table and sequences the Issue stage.
//            Define LAYER_SEQ_TIMEOUT_EN to enable the RUN-state watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_sequencer
    import layer_seq_pkg::*;
#(
    parameter int  NUM_LAYERS     = 8,
    parameter int  ARM_CYCLES     = 2,
    parameter int  TIMEOUT_CYCLES = 1_000_000,
    localparam int AW             = $clog2(NUM_LAYERS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [AW-1:0]     desc_addr,
    input  logic [DESC_W-1:0] desc_data,
    output logic [7:0]        image_dim,
    output logic [8:0]        image_depth,
    output logic [1:0]        filter_halfsize,
    output logic [2:0]        filter_stride,
    output logic              issue_rst,
    input  logic              issue_done,
    output logic              bank_sel,
    output logic [AW-1:0]     layer_idx,
    output logic              busy,
    output logic              all_done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int                  c_arm_w    = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
    localparam logic [c_arm_w-1:0]  c_arm_last = c_arm_w'(ARM_CYCLES - 1);
    localparam logic [AW-1:0]       c_last_idx = AW'(NUM_LAYERS - 1);

    seq_state_t         r_state;
    logic [AW-1:0]      r_desc_addr;
    logic [AW-1:0]      r_layer_idx;
    logic [7:0]         r_dim;
    logic [8:0]         r_depth;
    logic [1:0]         r_hs;
    logic [2:0]         r_stride;
    logic               r_last;
    logic               r_bank_sel;
    logic               r_issue_rst;
    logic               r_busy;
    logic               r_all_done;
    logic               r_err;
    logic [1:0]         r_err_code;
    logic [c_arm_w-1:0] r_arm_cnt;
    logic               w_desc_valid;

`ifdef LAYER_SEQ_TIMEOUT_EN
    localparam logic [31:0] c_tmo_last = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] r_run_cnt;
`endif

    layer_desc_check u_desc_check (
        .desc  (desc_data),
        .valid (w_desc_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_desc_addr <= '0;
            r_layer_idx <= '0;
            r_dim       <= '0;
            r_depth     <= '0;
            r_hs        <= '0;
            r_stride    <= '0;
            r_last      <= 1'b0;
            r_bank_sel  <= 1'b0;
            r_issue_rst <= 1'b1;
            r_busy      <= 1'b0;
            r_all_done  <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_arm_cnt   <= '0;
`ifdef LAYER_SEQ_TIMEOUT_EN
            r_run_cnt   <= '0;
`endif
        end else if (abort) begin
            r_state     <= ST_IDLE;
            r_desc_addr <= '0;
            r_layer_idx <= '0;
            r_bank_sel  <= 1'b0;
            r_issue_rst <= 1'b1;
            r_busy      <= 1'b0;
            r_all_done  <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_all_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_layer_idx <= '0;
                    r_bank_sel  <= 1'b0;
                    r_err       <= 1'b0;
                    r_err_code  <= ERR_NONE;
                    if (start) begin
                        r_state     <= ST_FETCH;
                        r_desc_addr <= '0;
                        r_busy      <= 1'b1;
                    end
                end
                ST_FETCH: r_state <= ST_LATCH;
                ST_LATCH: begin
                    r_dim    <= desc_data[DIM_LSB +: DIM_W];
                    r_depth  <= desc_data[DEPTH_LSB +: DEPTH_W];
                    r_hs     <= desc_data[HS_LSB +: HS_W];
                    r_stride <= desc_data[STRIDE_LSB +: STRIDE_W];
                    r_last   <= desc_data[LAST_BIT];
                    if (!w_desc_valid) begin
                        r_state    <= ST_ERROR;
                        r_err      <= 1'b1;
                        r_err_code <= ERR_DESC;
                    end else begin
                        r_state   <= ST_ARM;
                        r_arm_cnt <= '0;
                    end
                end
                ST_ARM: begin
                    if (r_arm_cnt == c_arm_last) begin
                        r_state     <= ST_RUN;
                        r_issue_rst <= 1'b0;
`ifdef LAYER_SEQ_TIMEOUT_EN
                        r_run_cnt   <= '0;
`endif
                    end else begin
                        r_arm_cnt <= r_arm_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (issue_done) begin
                        r_state     <= ST_NEXT;
                        r_issue_rst <= 1'b1;
`ifdef LAYER_SEQ_TIMEOUT_EN
                    end else if (r_run_cnt == c_tmo_last) begin
                        r_state     <= ST_ERROR;
                        r_issue_rst <= 1'b1;
                        r_err       <= 1'b1;
                        r_err_code  <= ERR_TIMEOUT;
                    end else begin
                        r_run_cnt <= r_run_cnt + 32'd1;
`endif
                    end
                end
                ST_NEXT: begin
                    r_bank_sel <= ~r_bank_sel;
                    if (r_last || (r_layer_idx == c_last_idx)) begin
                        r_state    <= ST_DONE;
                        r_all_done <= 1'b1;
                    end else begin
                        r_layer_idx <= r_layer_idx + 1'b1;
                        r_desc_addr <= r_layer_idx + 1'b1;
                        r_state     <= ST_FETCH;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                ST_ERROR: r_state <= ST_ERROR;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign desc_addr       = r_desc_addr;
    assign layer_idx       = r_layer_idx;
    assign image_dim       = r_dim;
    assign image_depth     = r_depth;
    assign filter_halfsize = r_hs;
    assign filter_stride   = r_stride;
    assign bank_sel        = r_bank_sel;
    assign issue_rst       = r_issue_rst;
    assign busy            = r_busy;
    assign all_done        = r_all_done;
    assign err             = r_err;
    assign err_code        = r_err_code;

endmodule

`default_nettype wire

// File: tb/tb_layer_sequencer.sv
// ============================================================================
// Module   : tb_layer_sequencer
// Brief    : Self-checking bench for layer_sequencer (table, directed, random).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_layer_sequencer;

    localparam int NL  = 4;
    localparam int ARM = 2;
    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        issue_done = 1'b0;
    logic [1:0]  desc_addr;
    logic [22:0] desc_data;
    logic [7:0]  image_dim;
    logic [8:0]  image_depth;
    logic [1:0]  filter_halfsize;
    logic [2:0]  filter_stride;
    logic        issue_rst;
    logic        bank_sel;
    logic [1:0]  layer_idx;
    logic        busy;
    logic        all_done;
    logic        err;
    logic [1:0]  err_code;

    logic [22:0] rom [NL];
    int          dly [NL];
    int          total = 0;
    int          bad   = 0;

    layer_sequencer #(
        .NUM_LAYERS     (NL),
        .ARM_CYCLES     (ARM),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .desc_addr       (desc_addr),
        .desc_data       (desc_data),
        .image_dim       (image_dim),
        .image_depth     (image_depth),
        .filter_halfsize (filter_halfsize),
        .filter_stride   (filter_stride),
        .issue_rst       (issue_rst),
        .issue_done      (issue_done),
        .bank_sel        (bank_sel),
        .layer_idx       (layer_idx),
        .busy            (busy),
        .all_done        (all_done),
        .err             (err),
        .err_code        (err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) desc_data <= rom[desc_addr];

    typedef struct {
        logic [22:0] d;
        bit          ok;
    } vec_t;

    function automatic logic [22:0] mk(input int dim, input int depth, input int hs,
                                       input int st, input int last);
        logic [7:0] v_dim;
        logic [8:0] v_depth;
        logic [1:0] v_hs;
        logic [2:0] v_st;
        logic       v_last;
        v_dim   = dim[7:0];
        v_depth = depth[8:0];
        v_hs    = hs[1:0];
        v_st    = st[2:0];
        v_last  = last[0];
        return {v_last, v_st, v_hs, v_depth, v_dim};
    endfunction

    function automatic bit desc_ok(input logic [22:0] d);
        int dim, depth, hs, st;
        dim   = int'(d[7:0]);
        depth = int'(d[16:8]);
        hs    = int'(d[18:17]);
        st    = int'(d[21:19]);
        return (dim != 0) && (depth != 0) && (st >= 1) && (st <= 4) && (dim >= 2 * hs + 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    // Runs the table currently in rom[] from start to its terminal event.
    task automatic do_run(input bit ign, input int abort_k, output bit saw_err);
        int  n_run, err_at, c, want, kind;
        bit  ok, stay;
        n_run   = 0;
        err_at  = -1;
        saw_err = 1'b0;
        for (int i = 0; i < NL; i++) begin
            if (!desc_ok(rom[i])) begin
                err_at = i;
                break;
            end
            n_run++;
            if (rom[i][22]) break;
        end
        start = 1'b1;
        for (int k = 0; k <= n_run; k++) begin
            if (k < n_run)        kind = 0;
            else if (err_at >= 0) kind = 1;
            else                  kind = 2;
            if (kind == 0)      want = (k == 0) ? 3 + ARM : 4 + ARM;
            else if (kind == 1) want = (k == 0) ? 3 : 4;
            else                want = 2;
            c  = 0;
            ok = 1'b0;
            while (c < 40 && !ok) begin
                @(negedge clk);
                c++;
                case (kind)
                    0:       ok = (issue_rst == 1'b0);
                    1:       ok = (err == 1'b1);
                    default: ok = (all_done == 1'b1);
                endcase
                if (c == 1) begin
                    start      = 1'b0;
                    issue_done = 1'b0;
                end
                if (ign && k == 0) issue_done = (c == 1 || c == 3);
            end
            issue_done = 1'b0;
            check($sformatf("layer%0d event latency", k), c, want);
            if (!ok) begin
                do_abort();
                return;
            end
            if (kind == 0) begin
                check($sformatf("layer%0d image_dim", k), image_dim, rom[k][7:0]);
                check($sformatf("layer%0d image_depth", k), image_depth, rom[k][16:8]);
                check($sformatf("layer%0d halfsize", k), filter_halfsize, rom[k][18:17]);
                check($sformatf("layer%0d stride", k), filter_stride, rom[k][21:19]);
                check($sformatf("layer%0d layer_idx", k), layer_idx, k);
                check($sformatf("layer%0d bank_sel", k), bank_sel, k % 2);
                check($sformatf("layer%0d busy", k), busy, 1);
                if (ign && k == 0) begin
                    repeat (3) @(negedge clk);
                    check("stray done issue_rst", issue_rst, 0);
                    check("stray done layer_idx", layer_idx, 0);
                end
                if (k == abort_k) begin
                    repeat (2) @(negedge clk);
                    do_abort();
                    check("abort busy", busy, 0);
                    check("abort issue_rst", issue_rst, 1);
                    check("abort layer_idx", layer_idx, 0);
                    check("abort err", err, 0);
                    c = 0;
                    repeat (10) begin
                        @(negedge clk);
                        if (all_done) c++;
                    end
                    check("abort no all_done", c, 0);
                    return;
                end
                stay = 1'b1;
                repeat (dly[k]) begin
                    @(negedge clk);
                    if (issue_rst || image_dim !== rom[k][7:0]) stay = 1'b0;
                end
                check($sformatf("layer%0d stable in run", k), stay, 1);
                issue_done = 1'b1;
            end else if (kind == 1) begin
                saw_err = 1'b1;
                check("desc err_code", err_code, 1);
                check("desc err layer_idx", layer_idx, err_at);
                check("desc err issue_rst", issue_rst, 1);
                check("desc err busy", busy, 1);
                start = 1'b1;
                repeat (3) @(negedge clk);
                start = 1'b0;
                check("error holds err", err, 1);
                check("error holds issue_rst", issue_rst, 1);
                do_abort();
                check("abort clears err", err, 0);
                check("abort clears err_code", err_code, 0);
                check("abort idle busy", busy, 0);
            end else begin
                check("done bank_sel", bank_sel, n_run % 2);
                check("done layer_idx", layer_idx, n_run - 1);
                @(negedge clk);
                check("all_done one pulse", all_done, 0);
                check("idle busy", busy, 0);
                check("idle issue_rst", issue_rst, 1);
                @(negedge clk);
                check("idle bank_sel", bank_sel, 0);
                check("idle layer_idx", layer_idx, 0);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [12];
        bit   se;
        int   c, dim, hs;

        vecs[0]  = '{mk(3, 1, 1, 1, 1), 1'b1};
        vecs[1]  = '{mk(2, 1, 1, 1, 1), 1'b0};
        vecs[2]  = '{mk(7, 5, 3, 2, 1), 1'b1};
        vecs[3]  = '{mk(6, 5, 3, 2, 1), 1'b0};
        vecs[4]  = '{mk(0, 5, 0, 1, 1), 1'b0};
        vecs[5]  = '{mk(9, 0, 0, 1, 1), 1'b0};
        vecs[6]  = '{mk(9, 511, 0, 4, 1), 1'b1};
        vecs[7]  = '{mk(9, 8, 0, 5, 1), 1'b0};
        vecs[8]  = '{mk(9, 8, 0, 0, 1), 1'b0};
        vecs[9]  = '{mk(255, 1, 3, 3, 1), 1'b1};
        vecs[10] = '{mk(1, 1, 0, 1, 1), 1'b1};
        vecs[11] = '{mk(255, 256, 2, 7, 1), 1'b0};

        for (int i = 0; i < NL; i++) begin
            rom[i] = '0;
            dly[i] = 3;
        end

        repeat (3) @(negedge clk);
        check("reset issue_rst", issue_rst, 1);
        check("reset busy", busy, 0);
        check("reset all_done", all_done, 0);
        check("reset err", err, 0);
        check("reset err_code", err_code, 0);
        check("reset desc_addr", desc_addr, 0);
        check("reset layer_idx", layer_idx, 0);
        check("reset bank_sel", bank_sel, 0);
        check("reset image_dim", image_dim, 0);
        check("reset image_depth", image_depth, 0);
        check("reset cfg hs/stride", {filter_halfsize, filter_stride}, 0);
        rst = 1'b1;
        @(negedge clk);

        // Descriptor validity table, each run as a single-layer table.
        for (int i = 0; i < 12; i++) begin
            rom[0] = vecs[i].d;
            do_run(1'b0, -1, se);
            check($sformatf("vec%0d valid", i), !se, vecs[i].ok);
        end

        // Three-layer run with last flag on layer 2.
        rom[0] = mk(46, 3, 1, 1, 0);
        rom[1] = mk(23, 16, 2, 1, 0);
        rom[2] = mk(11, 32, 1, 2, 1);
        rom[3] = mk(9, 9, 0, 1, 0);
        for (int i = 0; i < NL; i++) dly[i] = 50;
        do_run(1'b0, -1, se);
        check("three layer no err", se, 0);

        // Bad descriptor at layer 1.
        rom[1] = mk(2, 16, 1, 1, 0);
        for (int i = 0; i < NL; i++) dly[i] = 5;
        do_run(1'b0, -1, se);
        check("layer1 bad desc", se, 1);

        // No last flag: table depth bounds the run.
        rom[0] = mk(10, 4, 1, 1, 0);
        rom[1] = mk(20, 8, 2, 2, 0);
        rom[2] = mk(30, 12, 3, 3, 0);
        rom[3] = mk(40, 16, 0, 4, 0);
        do_run(1'b0, -1, se);
        check("four layer no err", se, 0);

        // Abort in RUN of layer 2.
        do_run(1'b0, 2, se);

        // issue_done pulses during FETCH and ARM are ignored.
        do_run(1'b1, -1, se);

        // start together with abort stays idle.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start+abort busy", busy, 0);
        repeat (6) @(negedge clk);
        check("start+abort issue_rst", issue_rst, 1);

        // Reset in the middle of RUN.
        start = 1'b1;
        c = 0;
        while (c < 20 && issue_rst) begin
            @(negedge clk);
            c++;
            start = 1'b0;
        end
        check("pre-reset release", issue_rst, 0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midrun rst issue_rst", issue_rst, 1);
        check("midrun rst busy", busy, 0);
        check("midrun rst image_dim", image_dim, 0);
        check("midrun rst layer_idx", layer_idx, 0);
        @(negedge clk);

`ifdef LAYER_SEQ_TIMEOUT_EN
        rom[0] = mk(46, 3, 1, 1, 1);
        start = 1'b1;
        c = 0;
        while (c < 20 && issue_rst) begin
            @(negedge clk);
            c++;
            start = 1'b0;
        end
        check("timeout release", issue_rst, 0);
        c = 0;
        while (c < 300 && !err) begin
            @(negedge clk);
            c++;
        end
        check("timeout cycles", c, TMO);
        check("timeout err_code", err_code, 2);
        check("timeout issue_rst", issue_rst, 1);
        do_abort();
        check("timeout abort err", err, 0);
`endif

        // Randomized tables against the descriptor-rule model.
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < NL; i++) begin
                if ($urandom_range(0, 9) == 0) begin
                    rom[i] = 23'($urandom);
                end else begin
                    dim = int'($urandom_range(1, 255));
                    hs  = int'($urandom_range(0, 3));
                    if (dim < 2 * hs + 1) hs = 0;
                    rom[i] = mk(dim, int'($urandom_range(1, 511)), hs,
                                int'($urandom_range(1, 4)),
                                ($urandom_range(0, 3) == 0) ? 1 : 0);
                end
                dly[i] = int'($urandom_range(1, 12));
            end
            do_run(1'b0, -1, se);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
